cla_adder_chunked: RTL and testbench
====================================

// Module: cla_adder_chunked
// PURPOSE
//  Multi-cycle parametrised adder/subtractor built from carry-lookahead slices. Processes a WIDTH-bit
//  operation CHUNK bits per cycle, LSB slice first, with the slice carry registered between cycles.
//  It replaces fixed 4-bit lookahead logic in the ALU datapath: ADD/ADC/SUB/SBC plus C/V/Z/S flags,
//  and a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK  4   bits resolved per cycle by one lookahead slice; 1 <= CHUNK <= WIDTH
//  (derived) NCHUNK = WIDTH/CHUNK, the number of RUN cycles per operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   2      00 ADD, 01 ADC, 10 SUB, 11 SBC
//  c_in       in   1      carry flag for ADC/SBC (SBC: 1 = no borrow)
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  result
//  c_out      out  1      carry out of MSB (SUB/SBC: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
//  sign       out  1      sum[WIDTH-1]
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE; in_ready=1 once released; out_valid=0; sum, c_out, ovf,
//    zero, sign all 0. Chunk counter and carry register 0. Reset mid-RUN/DONE aborts the operation
//    with no output. The first accept is possible on the first clk edge after rst_n rises.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid & in_ready: latch A; latch B' = B (ADD/ADC) or ~B (SUB/SBC);
//    set carry register to 0 (ADD), c_in (ADC), 1 (SUB), c_in (SBC); clear the counter; go to RUN.
//    RUN: in_ready=0. Each cycle, slice k = counter covers bits [k*CHUNK +: CHUNK].
//    p = A^B' and g = A&B'; carries come from the full lookahead expansion across the CHUNK bits
//    (no ripple). Write slice sum bits; carry register takes the slice carry out.
//    On the last slice (k = NCHUNK-1) capture c_out and ovf (from the carry into bit WIDTH-1), then
//    go to DONE. zero and sign are computed from the final sum.
//    DONE: out_valid=1. sum and the flags stay stable until handshake. On out_ready, go to IDLE next
//    cycle with out_valid=0.
//  - Latency: accept at edge E0; out_valid is high after edge E0+NCHUNK. Minimum spacing between
//    accepts is NCHUNK+2 cycles.
//  - a, b, op and c_in are sampled only at accept. Changes during RUN/DONE are ignored.
//  - sum and the flags are not updated during RUN on the external ports. They hold the previous
//    result until DONE. Internal partial sum is kept in a separate register.
//  - out_ready while out_valid=0 has no effect. in_valid outside IDLE is ignored and is not queued.
//  - The WIDTH sum wraps modulo 2^WIDTH. CHUNK=WIDTH gives a 1-cycle RUN (pure lookahead).
// TESTING
//  T1 WIDTH16/CHUNK4, ADD 0xFFFF+0x0001 -> sum 0x0000, c_out1, zero1, ovf0, sign0.
//     out_valid rises exactly 4 cycles after accept.
//  T2 ADD 0x7FFF+0x0001 -> sum 0x8000, ovf1, sign1, c_out0.
//     ADC 0x1234+0x1111 with c_in=1 -> 0x2346, c_out0.
//  T3 SUB 0x0005-0x0007 -> 0xFFFE, c_out0, sign1, ovf0.
//     SBC 0x0010-0x0001 with c_in=0 -> 0x000E, c_out1.
//     SUB 0x8000-0x0001 -> 0x7FFF, ovf1.
//  T4 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/flags/out_valid stable.
//     in_valid is pulsed during RUN/DONE -> no second accept and in_ready stays 0.
//  T5 Reset: assert rst_n low in cycle 2 of RUN -> out_valid never rises, all outputs read 0.
//     A new ADD 0x0003+0x0004 after release -> 0x0007.
//  T6 Parameter sweep: CHUNK=16 (1-cycle RUN), CHUNK=1, and WIDTH=32/CHUNK=8.
//     Random ops are checked against a behavioural a+b / a-b model, including flags and latency NCHUNK.

Source files
------------

// File: rtl/cla_adder_chunked_if.sv
// Request/response bundle for the chunked carry-lookahead adder.
// master drives operands and out_ready; slave returns result and flags.
interface cla_adder_chunked_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic             zero;
   logic             sign;

   modport master (
      output in_valid, a, b, op, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, zero, sign
   );

   modport slave (
      input  in_valid, a, b, op, c_in, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, zero, sign
   );
endinterface

// File: rtl/cla_adder_chunked.sv
// Multi-cycle add/sub: one CHUNK-bit carry-lookahead slice per cycle,
// LSB slice first, slice carry registered between cycles.
module cla_adder_chunked #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                clk,
   input logic                rst_n,
   cla_adder_chunked_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             zero_q;
   logic             sign_q;
   logic [CHUNK-1:0] p;
   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] s;
   logic [CHUNK:0]   c;
   logic             term;
   logic             cy;
   logic             accept;
   logic             last;
   int               base;

   assign accept = (state_q == IDLE) && bus.in_valid;
   assign last   = (cnt_q == LAST);

   // every carry is a flat sum of products of g, p and the slice carry-in
   always_comb begin
      base  = int'(cnt_q) * CHUNK;
      p     = a_q[base +: CHUNK] ^ b_q[base +: CHUNK];
      g     = a_q[base +: CHUNK] & b_q[base +: CHUNK];
      c     = '0;
      term  = 1'b0;
      cy    = 1'b0;
      c[0]  = carry_q;
      for (int i = 0; i < CHUNK; i++) begin
         term = carry_q;
         for (int k = 0; k <= i; k++) begin
            term = term & p[k];
         end
         cy = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            cy = cy | term;
         end
         c[i+1] = cy;
      end
      s     = p ^ c[CHUNK-1:0];
      acc_d = acc_q;
      acc_d[base +: CHUNK] = s;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.op[1] ? ~bus.b : bus.b;
         // ADD:0  ADC:c_in  SUB:1  SBC:c_in
         carry_q <= bus.op[0] ? bus.c_in : bus.op[1];
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         acc_q   <= acc_d;
         carry_q <= c[CHUNK];
         cnt_q   <= cnt_q + 1'b1;
         if (last) begin
            sum_q   <= acc_d;
            c_out_q <= c[CHUNK];
            ovf_q   <= c[CHUNK] ^ c[CHUNK-1];
            zero_q  <= (acc_d == '0);
            sign_q  <= acc_d[WIDTH-1];
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.sign      = sign_q;
endmodule

// File: tb/tb_cla_adder_chunked.sv
// Bench for cla_adder_chunked: directed table, handshake/reset corners,
// and random ops on four WIDTH/CHUNK configurations against an arithmetic model.
module tb_cla_adder_chunked;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   sweep_go = 1'b0;
   int   sweep_cnt = 0;

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // plain integer arithmetic: unsigned result/carry, signed range for ovf
   function automatic void model(input int w, input longint unsigned a,
                                 input longint unsigned b, input logic [1:0] op,
                                 input logic cin, output longint unsigned s,
                                 output logic c, output logic v,
                                 output logic z, output logic sg);
      longint unsigned m;
      longint unsigned full;
      longint          sa;
      longint          sb;
      longint          r;
      longint          ci;
      m = (64'd1 << w) - 1;
      case (op)
         2'd0:    ci = 0;
         2'd1:    ci = cin ? 1 : 0;
         2'd2:    ci = 0;
         default: ci = cin ? 0 : 1;
      endcase
      sa = longint'(a);
      sb = longint'(b);
      if (((a >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
      if (((b >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
      if (op[1] == 1'b0) begin
         full = a + b + longint'(ci);
         c = ((full >> w) & 1) == 1;
         r = sa + sb + ci;
      end else begin
         full = a - b - longint'(ci);
         c = (a >= b + longint'(ci));
         r = sa - sb - ci;
      end
      v  = (r < -(longint'(1) << (w - 1))) || (r > (longint'(1) << (w - 1)) - 1);
      s  = full & m;
      z  = (s == 0);
      sg = ((s >> (w - 1)) & 1) == 1;
   endfunction

   // main instance: WIDTH 16, CHUNK 4
   cla_adder_chunked_if #(.WIDTH(16)) b0 ();
   cla_adder_chunked #(.WIDTH(16), .CHUNK(4)) u0 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b0)
   );

   task automatic start0(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic cin);
      int k;
      k = 0;
      while (!b0.in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!b0.in_ready) check("start0 ready timeout", b0.in_ready, 1);
      b0.a = a;
      b0.b = b;
      b0.op = op;
      b0.c_in = cin;
      b0.in_valid = 1'b1;
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
   endtask

   task automatic wait0(output int lat);
      lat = 0;
      while (!b0.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop0();
      b0.out_ready = 1'b1;
      @(posedge clk); #1;
      b0.out_ready = 1'b0;
   endtask

   task automatic res0(input string n, input logic [15:0] es, input logic ec,
                       input logic ev, input logic ez, input logic eg);
      check({n, " sum"}, b0.sum, es);
      check({n, " c_out"}, b0.c_out, ec);
      check({n, " ovf"}, b0.ovf, ev);
      check({n, " zero"}, b0.zero, ez);
      check({n, " sign"}, b0.sign, eg);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic        cin;
      logic [15:0] sum;
      logic        c;
      logic        v;
      logic        z;
      logic        s;
   } vec_t;

   vec_t tbl[7];

   // parameter sweep instances
   for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int ID = gi;
      localparam int W = (gi == 2) ? 32 : 16;
      localparam int C = (gi == 0) ? 16 : (gi == 1) ? 1 : 8;
      localparam int N = W / C;

      cla_adder_chunked_if #(.WIDTH(W)) bs ();
      cla_adder_chunked #(.WIDTH(W), .CHUNK(C)) us (
         .clk  (clk),
         .rst_n(rst_n),
         .bus  (bs)
      );

      initial begin
         logic [W-1:0]    ra;
         logic [W-1:0]    rb;
         logic [1:0]      rop;
         logic            rc;
         int              lat;
         longint unsigned es;
         logic            ec;
         logic            ev;
         logic            ez;
         logic            eg;
         string           nm;
         bs.in_valid = 1'b0;
         bs.out_ready = 1'b0;
         bs.a = '0;
         bs.b = '0;
         bs.op = 2'd0;
         bs.c_in = 1'b0;
         wait (sweep_go);
         @(posedge clk); #1;
         for (int i = 0; i < 30; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            if (i == 0) begin
               ra = '1;
               rb = W'(1);
               rop = 2'd0;
            end
            if (i == 1) begin
               ra = '0;
               ra[W-1] = 1'b1;
               rb = W'(1);
               rop = 2'd2;
            end
            nm = $sformatf("sw%0d op%0d", ID, i);
            model(W, longint'(ra), longint'(rb), rop, rc, es, ec, ev, ez, eg);
            if (!bs.in_ready) check({nm, " ready"}, bs.in_ready, 1);
            bs.a = ra;
            bs.b = rb;
            bs.op = rop;
            bs.c_in = rc;
            bs.in_valid = 1'b1;
            @(posedge clk); #1;
            bs.in_valid = 1'b0;
            lat = 0;
            while (!bs.out_valid && lat < 100) begin
               @(posedge clk); #1;
               lat++;
            end
            check({nm, " latency"}, 64'(lat), 64'(N));
            check({nm, " sum"}, 64'(bs.sum), es);
            check({nm, " c_out"}, bs.c_out, ec);
            check({nm, " ovf"}, bs.ovf, ev);
            check({nm, " zero"}, bs.zero, ez);
            check({nm, " sign"}, bs.sign, eg);
            bs.out_ready = 1'b1;
            @(posedge clk); #1;
            bs.out_ready = 1'b0;
            check({nm, " out_valid drop"}, bs.out_valid, 0);
         end
         sweep_cnt++;
      end
   end

   initial begin
      int              lat;
      logic [15:0]     ra;
      logic [15:0]     rb;
      logic [1:0]      rop;
      logic            rc;
      longint unsigned es;
      logic            ec;
      logic            ev;
      logic            ez;
      logic            eg;
      string           nm;

      tbl[0] = '{16'hFFFF, 16'h0001, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h0001, 2'd0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{16'h1234, 16'h1111, 2'd1, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{16'h0005, 16'h0007, 2'd2, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{16'h0010, 16'h0001, 2'd3, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{16'h8000, 16'h0001, 2'd2, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{16'h1234, 16'h1234, 2'd2, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

      b0.in_valid = 1'b0;
      b0.out_ready = 1'b0;
      b0.a = '0;
      b0.b = '0;
      b0.op = 2'd0;
      b0.c_in = 1'b0;

      #22 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset in_ready", b0.in_ready, 1);
      check("reset out_valid", b0.out_valid, 0);
      res0("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // directed vectors
      for (int i = 0; i < 7; i++) begin
         nm = $sformatf("vec%0d", i);
         start0(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].cin);
         wait0(lat);
         check({nm, " latency"}, 64'(lat), 64'd4);
         res0(nm, tbl[i].sum, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].s);
         pop0();
         check({nm, " out_valid drop"}, b0.out_valid, 0);
      end

      // backpressure, ignored in_valid during RUN and DONE
      start0(16'h9000, 16'h9000, 2'd0, 1'b0);
      @(posedge clk); #1;
      b0.a = 16'h0001;
      b0.b = 16'h0001;
      b0.in_valid = 1'b1;
      check("bp in_ready run", b0.in_ready, 0);
      @(posedge clk); #1;
      b0.in_valid = 1'b0;
      wait0(lat);
      check("bp out_valid", b0.out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         nm = $sformatf("bp hold%0d", i);
         check({nm, " out_valid"}, b0.out_valid, 1);
         check({nm, " in_ready"}, b0.in_ready, 0);
         res0(nm, 16'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
         b0.in_valid = (i == 2);
         @(posedge clk); #1;
      end
      b0.in_valid = 1'b0;
      res0("bp final", 16'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
      pop0();
      for (int i = 0; i < 6; i++) begin
         check("bp no second op", b0.out_valid, 0);
         check("bp idle ready", b0.in_ready, 1);
         @(posedge clk); #1;
      end

      // reset mid-RUN aborts the operation
      start0(16'h1111, 16'h2222, 2'd0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", b0.out_valid, 0);
      res0("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("rst no result", b0.out_valid, 0);
         @(posedge clk); #1;
      end
      start0(16'h0003, 16'h0004, 2'd0, 1'b0);
      wait0(lat);
      check("post-rst latency", 64'(lat), 64'd4);
      res0("post-rst", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
      pop0();

      // random ops on the main instance
      for (int i = 0; i < 40; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rop = 2'($urandom_range(0, 3));
         rc  = 1'($urandom_range(0, 1));
         nm  = $sformatf("rnd%0d", i);
         model(16, longint'(ra), longint'(rb), rop, rc, es, ec, ev, ez, eg);
         start0(ra, rb, rop, rc);
         wait0(lat);
         check({nm, " latency"}, 64'(lat), 64'd4);
         res0(nm, 16'(es), ec, ev, ez, eg);
         pop0();
      end

      sweep_go = 1'b1;
      for (int k = 0; k < 20000 && sweep_cnt < 3; k++) begin
         @(posedge clk);
      end
      check("sweep completion", 64'(sweep_cnt), 64'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
